// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-style memory port between instruction-fetch (i) and data (d) requesters.
// Tie-break policy: fixed D-over-I by default; define ARB_ROUND_ROBIN_EN for round-robin.
module mem_bus_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_waitrequest,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_waitrequest,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_waitrequest
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT_DATA, DONE} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_t            state_q, state_n;
  grant_t            grant_q, grant_n;
  logic              last_d_q, last_d_n;   // 1: last completed grant was D
  logic [2:0]        cnt_q, cnt_n;
  mem_cmd_t          cmd_q, cmd_n;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_n;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_n;

  logic i_req, d_req, pick_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the requester that did not win last time goes first.
  assign pick_d = d_req & (~i_req | ~last_d_q);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= GNT_NONE;
      last_d_q  <= 1'b1;
      cnt_q     <= '0;
      cmd_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_n;
      grant_q   <= grant_n;
      last_d_q  <= last_d_n;
      cnt_q     <= cnt_n;
      cmd_q     <= cmd_n;
      i_rdata_q <= i_rdata_n;
      d_rdata_q <= d_rdata_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    grant_n   = grant_q;
    last_d_n  = last_d_q;
    cnt_n     = cnt_q;
    cmd_n     = cmd_q;
    i_rdata_n = i_rdata_q;
    d_rdata_n = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_n = CMD;
          if (pick_d) begin
            // A simultaneous read+write from D is a write; the read is dropped.
            grant_n     = GNT_D;
            cmd_n.wr    = d_write;
            cmd_n.rd    = ~d_write;
            cmd_n.be    = d_byteenable;
            cmd_n.addr  = d_address;
            cmd_n.wdata = d_writedata;
          end else begin
            grant_n    = GNT_I;
            cmd_n.wr   = 1'b0;
            cmd_n.rd   = 1'b1;
            cmd_n.be   = '1;
            cmd_n.addr = i_address;
          end
        end
      end
      CMD: begin
        if (!mem_waitrequest) begin
          cmd_n.rd = 1'b0;
          cmd_n.wr = 1'b0;
          if (cmd_q.wr) begin
            state_n = DONE;
          end else begin
            cnt_n   = CNT_INIT;
            state_n = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (cnt_q == '0) begin
          if (grant_q == GNT_I) i_rdata_n = mem_readdata;
          else                  d_rdata_n = mem_readdata;
          state_n = DONE;
        end else begin
          cnt_n = cnt_q - 3'd1;
        end
      end
      DONE: begin
        last_d_n = (grant_q == GNT_D);
        grant_n  = GNT_NONE;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_read       = cmd_q.rd;
  assign mem_write      = cmd_q.wr;
  assign mem_byteenable = cmd_q.be;
  assign mem_address    = cmd_q.addr;
  assign mem_writedata  = cmd_q.wdata;

  assign i_readdata    = i_rdata_q;
  assign d_readdata    = d_rdata_q;
  assign i_waitrequest = ~((state_q == DONE) && (grant_q == GNT_I));
  assign d_waitrequest = ~((state_q == DONE) && (grant_q == GNT_D));

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single Avalon-style memory port (RAM model or external bus) between the CPU's instruction-fetch and data (load/store) requesters.
- Accepts one transaction at a time and forwards it to memory with registered command signals.
- Honours mem_waitrequest, waits a fixed read latency, returns readdata to the granted requester, and signals completion by dropping that requester's waitrequest for one cycle.

Parameters:
- READ_LATENCY, 1, cycles from read command acceptance (mem_waitrequest low) to mem_readdata valid; legal range 1..7.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable is DATA_W/8 bits.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active-low.
- i_read  in  1  instruction-fetch read request.
- i_address  in  ADDR_W  fetch address.
- i_readdata  out  DATA_W  fetched word; held until the next i completion.
- i_waitrequest  out  1  low for exactly one cycle when the i transaction completes.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_byteenable  in  4  write/read byte lanes.
- d_address  in  ADDR_W  data address.
- d_writedata  in  DATA_W  store data.
- d_readdata  out  DATA_W  load data; held until the next d read completion.
- d_waitrequest  out  1  low for exactly one cycle when the d transaction completes.
- mem_read  out  1  registered read command to memory.
- mem_write  out  1  registered write command to memory.
- mem_byteenable  out  4  registered byte lanes; 4'b1111 for i reads.
- mem_address  out  ADDR_W  registered address.
- mem_writedata  out  DATA_W  registered store data.
- mem_readdata  in  DATA_W  memory read data.
- mem_waitrequest  in  1  memory stall.

Behaviour:
- States: IDLE, CMD, WAIT_DATA, DONE. Reset (reset_n low at a clk edge) forces IDLE, even mid-transaction; the in-flight transaction is abandoned.
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0, i_readdata=0, d_readdata=0, i_waitrequest=1, d_waitrequest=1, grant=none, last_grant=D.
- IDLE:
  - Sample requests. Arbitrate if any i_read / d_read / d_write is high.
  - Latch the winner's address, data and byteenable into the mem_* registers and assert mem_read or mem_write.
  - Go to CMD.
- d_read and d_write both high: treated as a write; the read is ignored.
- CMD:
  - Hold all mem_* outputs stable while mem_waitrequest=1.
  - On an edge with mem_waitrequest=0, deassert mem_read/mem_write.
  - Write: go to DONE. Read: load latency counter with READ_LATENCY-1 and go to WAIT_DATA.
- WAIT_DATA:
  - Decrement the counter each cycle.
  - At 0, capture mem_readdata into the granted port's readdata and go to DONE.
- DONE:
  - Granted port's waitrequest=0 for this single cycle; all other cycles it is 1.
  - Update last_grant; return to IDLE.
  - Requests are not sampled in DONE. A requester holding its request after completion is treated as a new transaction in IDLE.
- Non-granted requester: its waitrequest stays 1; it must hold its inputs stable until served (not checked).
- Minimum read timing (READ_LATENCY=1, no stall):
  - request seen in IDLE at cycle 0;
  - mem_read high in cycle 1;
  - data captured at end of cycle 2;
  - waitrequest low in cycle 3.
  - Total: 4 cycles.
- Minimum write timing: 3 cycles.
- Address and byteenable pass through unchanged; no alignment checks or address mapping.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester other than last_grant wins. Reset last_grant=D, so I wins the first tie.
- Undefined: fixed priority; D always beats I. last_grant is still updated but unused.

Test Plan:
- Single i_read addr 0xBFC00000, memory returns 0x3C011234, no stalls -> mem_read high in cycle 1 with mem_byteenable=4'b1111; i_readdata=0x3C011234 and i_waitrequest=0 in cycle 3 only.
- d_write addr 0x00001000, data 0xDEADBEEF, be 4'b0011, mem_waitrequest high 3 cycles -> mem_write/mem_address/mem_writedata/mem_byteenable held stable all 4 CMD cycles; d_waitrequest low exactly once, 1 cycle after acceptance.
- i_read and d_read simultaneous, held continuously:
  - with ARB_ROUND_ROBIN_EN: grant order I, D, I, D;
  - without it: D is granted on every transaction and I never completes.
- READ_LATENCY=3, d_read 0x20 -> data captured 3 cycles after acceptance; the value on mem_readdata at 1 and 2 cycles after acceptance is ignored.
- reset_n low during CMD of a pending write -> next cycle: mem_write=0, both waitrequests=1, state IDLE; no completion pulse ever issued for that write.
- d_read and d_write both high, addr 0x40 -> only mem_write asserted; d_readdata unchanged.
